// File: rtl/timestamp_fifo.sv
// timestamp_fifo: captures the upstream timer count on hardware events into a
// FIFO. Software reads the FIFO over an Avalon-MM slave with registered readdata.
// Optional build macro TSFIFO_EDGE_EN: capture on the rising edge of event_in
// instead of on every cycle that event_in is high.
`timescale 1ns/1ps
module timestamp_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int TS_WIDTH   = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [TS_WIDTH-1:0] timer_count,
    input  logic                event_in,
    input  logic [7:0]          address,
    input  logic                write,
    input  logic [31:0]         writedata,
    input  logic                read,
    output logic [31:0]         readdata,
    output logic                irq
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = (DEPTH_LOG2)'(1);

    logic [TS_WIDTH-1:0]   mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic                  enable_q, enable_d;
    logic [15:0]           drop_q, drop_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  irq_q;
    logic [15:0]           status_lo;
    logic                  empty, full, ctrl_wr, clear, cap_cond, capture, pop, push, drop;
    logic                  unused_wdata;

    // Only the two control bits of writedata carry meaning.
    assign unused_wdata = ^writedata[31:2];

`ifdef TSFIFO_EDGE_EN
    logic evt_q;
    // Delayed copy of event_in for rising-edge detection; resets high so an
    // event held through reset does not capture on release.
    always_ff @(posedge clk) begin
        if (reset) evt_q <= 1'b1;
        else       evt_q <= event_in;
    end
    assign cap_cond = event_in & ~evt_q;
`else
    assign cap_cond = event_in;
`endif

    // Capture/pop/clear decode, register read mux and next-state computation.
    always_comb begin
        empty    = (level_q == '0);
        full     = (level_q == LVL_FULL);
        ctrl_wr  = write && (address == 8'd2);
        clear    = ctrl_wr && writedata[1];
        capture  = enable_q && cap_cond;
        pop      = read && (address == 8'd0) && !empty;
        // A same-cycle pop frees the slot, so a capture into a full FIFO survives.
        push     = capture && (!full || pop);
        drop     = capture && full && !pop;

        status_lo                  = '0;
        status_lo[0]               = empty;
        status_lo[1]               = full;
        status_lo[2]               = enable_q;
        status_lo[8 +: DEPTH_LOG2+1] = level_q;

        rdata_d = rdata_q;
        if (read) begin
            case (address)
                8'd0:    rdata_d = empty ? 32'd0 : 32'(mem_q[rd_ptr_q]);
                8'd1:    rdata_d = {drop_q, status_lo};
                8'd2:    rdata_d = {31'd0, enable_q};
                default: rdata_d = 32'd0;
            endcase
        end

        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        level_d  = level_q;
        if (push && !pop)      level_d = level_q + LVL_ONE;
        else if (pop && !push) level_d = level_q - LVL_ONE;
        drop_d   = (drop && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
        enable_d = ctrl_wr ? writedata[0] : enable_q;

        // Clear overrides any capture or pop in the same cycle.
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            drop_d   = '0;
        end
    end

    // State registers; irq follows the registered state one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            enable_q <= 1'b0;
            drop_q   <= '0;
            rdata_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            enable_q <= enable_d;
            drop_q   <= drop_d;
            rdata_q  <= rdata_d;
            irq_q    <= enable_q && !empty;
        end
    end

    // Sample storage; contents are meaningless outside the pointer window, so no reset.
    always_ff @(posedge clk) begin
        if (push && !clear && !reset) mem_q[wr_ptr_q] <= timer_count;
    end

    assign readdata = rdata_q;
    assign irq      = irq_q;
endmodule

// File: tb/tb_timestamp_fifo.sv
// Bench for timestamp_fifo: directed steps from the test plan followed by a
// randomized phase, all checked against a queue-based reference model.
`timescale 1ns/1ps
module tb_timestamp_fifo;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] timer_count = '0;
    logic        event_in = 1'b0;
    logic [7:0]  address = '0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic        read = 1'b0;
    logic [31:0] readdata;
    logic        irq;

    always #5 clk = ~clk;

    timestamp_fifo dut (
        .clk(clk), .reset(reset), .timer_count(timer_count), .event_in(event_in),
        .address(address), .write(write), .writedata(writedata), .read(read),
        .readdata(readdata), .irq(irq)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: queue of timestamps, drop counter, enable flag.
    logic [31:0] mq[$];
    int unsigned drops = 0;
    bit          men = 1'b0;
    logic [31:0] last_rd = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_status();
        int unsigned lvl = mq.size();
        return (32'(drops) << 16) | (32'(lvl) << 8) | (32'(men) << 2)
             | (32'(lvl == 16) << 1) | 32'(lvl == 0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        mq.delete();
        drops   = 0;
        men     = 1'b0;
        last_rd = '0;
    endtask

    // One bus/event cycle followed by one idle cycle; checks readdata after the
    // active cycle and irq at both edges.
    task automatic do_cycle(input bit cap, input logic [31:0] ts, input bit rd,
                            input logic [7:0] ra, input bit wr, input logic [7:0] wa,
                            input logic [31:0] wd, input string tag);
        logic [31:0] exp_rd  = last_rd;
        bit          pre_irq = men && (mq.size() > 0);
        bit          popped  = 1'b0;
        if (rd) begin
            case (ra)
                8'd0: begin
                    if (mq.size() > 0) begin exp_rd = mq[0]; popped = 1'b1; end
                    else exp_rd = 32'd0;
                end
                8'd1:    exp_rd = model_status();
                8'd2:    exp_rd = {31'd0, men};
                default: exp_rd = 32'd0;
            endcase
        end
        if (popped) void'(mq.pop_front());
        if (cap && men) begin
            if (mq.size() < 16) mq.push_back(ts);
            else if (drops < 16'hFFFF) drops++;
        end
        if (wr && wa == 8'd2) begin
            if (wd[1]) begin mq.delete(); drops = 0; end
            men = wd[0];
        end

        event_in = cap; timer_count = ts; read = rd; write = wr;
        address = rd ? ra : wa; writedata = wd;
        tick();
        check({tag, ".rdata"}, readdata, exp_rd);
        check({tag, ".irq0"}, {31'd0, irq}, {31'd0, pre_irq});
        last_rd = exp_rd;
        event_in = 1'b0; read = 1'b0; write = 1'b0;
        tick();
        check({tag, ".irq1"}, {31'd0, irq}, {31'd0, men && (mq.size() > 0)});
    endtask

    task automatic cap_ts(input logic [31:0] ts, input string tag);
        do_cycle(1'b1, ts, 1'b0, 8'd0, 1'b0, 8'd0, 32'd0, tag);
    endtask
    task automatic rd_reg(input logic [7:0] a, input string tag);
        do_cycle(1'b0, 32'd0, 1'b1, a, 1'b0, 8'd0, 32'd0, tag);
    endtask
    task automatic wr_ctrl(input logic [31:0] d, input string tag);
        do_cycle(1'b0, 32'd0, 1'b0, 8'd0, 1'b1, 8'd2, d, tag);
    endtask

    initial begin
        tick(); tick();
        reset = 1'b0;
        model_reset();
        check("reset.rdata", readdata, 32'd0);
        check("reset.irq", {31'd0, irq}, 32'd0);

        // Reset status.
        rd_reg(8'd1, "status0");
        check("status0.const", readdata, 32'h0000_0001);

        // Single capture and pop.
        wr_ctrl(32'h1, "enable");
        rd_reg(8'd2, "ctrl_rd");
        cap_ts(32'h100, "cap100");
        rd_reg(8'd0, "pop100");
        check("pop100.const", readdata, 32'h0000_0100);
        rd_reg(8'd1, "status_empty");

        // Fill, overflow by three, drain.
        for (int i = 0; i < 16; i++) cap_ts(32'(i), "fill");
        for (int i = 0; i < 3; i++) cap_ts(32'(200 + i), "ovf");
        rd_reg(8'd1, "status_full");
        check("status_full.const", readdata, 32'h0003_1006);
        for (int i = 0; i < 16; i++) rd_reg(8'd0, "drain");
        rd_reg(8'd0, "pop_empty");

        // Capture and pop together while full.
        for (int i = 0; i < 16; i++) cap_ts(32'(i), "fill2");
        do_cycle(1'b1, 32'hAA, 1'b1, 8'd0, 1'b0, 8'd0, 32'd0, "cap_pop_full");
        rd_reg(8'd1, "status_full2");
        for (int i = 0; i < 16; i++) rd_reg(8'd0, "drain2");
        check("drain2.last", readdata, 32'h0000_00AA);

        // Clear collides with a capture.
        for (int i = 0; i < 5; i++) cap_ts(32'(300 + i), "five");
        do_cycle(1'b1, 32'h777, 1'b0, 8'd0, 1'b1, 8'd2, 32'h3, "clear_cap");
        rd_reg(8'd1, "status_clr");
        check("status_clr.const", readdata, 32'h0000_0005);
        rd_reg(8'd0, "pop_clr");

        // Held-high event.
        for (int i = 0; i < 10; i++) begin
            timer_count = 32'(32'h500 + i);
            event_in = 1'b1;
            tick();
`ifdef TSFIFO_EDGE_EN
            if (i == 0) mq.push_back(32'(32'h500 + i));
`else
            mq.push_back(32'(32'h500 + i));
`endif
        end
        event_in = 1'b0;
        tick();
        rd_reg(8'd1, "held_status");
`ifdef TSFIFO_EDGE_EN
        check("held.level", {27'd0, readdata[12:8]}, 32'd1);
`else
        check("held.level", {27'd0, readdata[12:8]}, 32'd10);
`endif
        rd_reg(8'd0, "held_pop");

        // Disable keeps data readable and blocks captures.
        wr_ctrl(32'h0, "disable");
        cap_ts(32'h999, "cap_dis");
        rd_reg(8'd1, "status_dis");
        rd_reg(8'd0, "pop_dis");

        // Reset mid-operation.
        wr_ctrl(32'h1, "reenable");
        for (int i = 0; i < 4; i++) cap_ts(32'(400 + i), "pre_rst");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        check("midrst.rdata", readdata, 32'd0);
        check("midrst.irq", {31'd0, irq}, 32'd0);
        rd_reg(8'd1, "status_rst");
        check("status_rst.const", readdata, 32'h0000_0001);

        // Randomized traffic.
        wr_ctrl(32'h1, "rnd_en");
        for (int n = 0; n < 600; n++) begin
            int unsigned op = $urandom_range(0, 9);
            logic [31:0] ts = $urandom;
            case (op)
                0, 1, 2, 3: cap_ts(ts, "rnd_cap");
                4, 5:       rd_reg(8'd0, "rnd_pop");
                6:          rd_reg(8'd1, "rnd_stat");
                7:          do_cycle(1'b1, ts, 1'b1, 8'd0, 1'b0, 8'd0, 32'd0, "rnd_cappop");
                8:          wr_ctrl({30'd0, $urandom_range(0, 7) == 0, $urandom_range(0, 5) != 0}, "rnd_ctrl");
                default: begin
                    if ($urandom_range(0, 1) == 0)
                        rd_reg(8'($urandom_range(2, 255)), "rnd_rdx");
                    else
                        do_cycle(1'b0, 32'd0, 1'b0, 8'd0, 1'b1, 8'($urandom_range(3, 255)), $urandom, "rnd_wrx");
                end
            endcase
        end
        rd_reg(8'd1, "final_status");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
